// File: rtl/vrb_arb2_if.sv
// vrb bus bundle: command channel (master -> slave) and response channel (slave -> master).
interface vrb_arb2_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [AW-1:0]   cmd_addr;
   logic            cmd_read;
   logic [DW-1:0]   cmd_wdata;
   logic [DW/8-1:0] cmd_wmask;
   logic            rsp_valid;
   logic            rsp_ready;
   logic            rsp_err;
   logic [DW-1:0]   rsp_rdata;

   modport master (
      output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
      output cmd_ready, rsp_valid, rsp_err, rsp_rdata
   );
endinterface

// File: rtl/vrb_arb2.sv
// Two-master to one-slave vrb arbiter: round-robin with grant lock, in-order ID FIFO
// routes each slave response back to the master that issued the command.
module vrb_arb2 #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned OUTS_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   vrb_arb2_if.slave                   m0,
   vrb_arb2_if.slave                   m1,
   vrb_arb2_if.master                  s,
   output logic [$clog2(OUTS_DEPTH):0] outs_cnt
);
   localparam int unsigned PW = $clog2(OUTS_DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic ID_M0 = 1'b0;
   localparam logic ID_M1 = 1'b1;

   logic [CW-1:0]         cnt;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;
   logic [OUTS_DEPTH-1:0] id_fifo;
   logic                  lock;
   logic                  locked_id;
   logic                  last_grant;

   logic                  full;
   logic                  nonempty;
   logic                  grant;
   logic                  head;
   logic                  push;
   logic                  pop;
   logic                  valid_sel;
   logic                  read_sel;
   logic [AW-1:0]         addr_sel;
   logic [DW-1:0]         wdata_sel;
   logic [DW/8-1:0]       wmask_sel;

   assign full     = (cnt == CW'(OUTS_DEPTH));
   assign nonempty = (cnt != '0);

   // A stalled command keeps the grant; otherwise a lone requester wins, ties alternate.
   always_comb begin
      grant = ~last_grant;
      if (lock) begin
         grant = locked_id;
      end else if (m0.cmd_valid && !m1.cmd_valid) begin
         grant = ID_M0;
      end else if (m1.cmd_valid && !m0.cmd_valid) begin
         grant = ID_M1;
      end
   end

   always_comb begin
      valid_sel = m0.cmd_valid;
      read_sel  = m0.cmd_read;
      addr_sel  = m0.cmd_addr;
      wdata_sel = m0.cmd_wdata;
      wmask_sel = m0.cmd_wmask;
      if (grant == ID_M1) begin
         valid_sel = m1.cmd_valid;
         read_sel  = m1.cmd_read;
         addr_sel  = m1.cmd_addr;
         wdata_sel = m1.cmd_wdata;
         wmask_sel = m1.cmd_wmask;
      end
   end

   assign s.cmd_valid  = valid_sel & ~full;
   assign s.cmd_read   = read_sel;
   assign s.cmd_addr   = addr_sel;
   assign s.cmd_wdata  = wdata_sel;
   assign s.cmd_wmask  = wmask_sel;
   assign m0.cmd_ready = (grant == ID_M0) & s.cmd_ready & ~full;
   assign m1.cmd_ready = (grant == ID_M1) & s.cmd_ready & ~full;

   // Response goes to the FIFO head owner; with nothing outstanding it is swallowed.
   assign head         = id_fifo[rd_ptr];
   assign m0.rsp_valid = s.rsp_valid & nonempty & (head == ID_M0);
   assign m1.rsp_valid = s.rsp_valid & nonempty & (head == ID_M1);
   assign m0.rsp_err   = s.rsp_err;
   assign m1.rsp_err   = s.rsp_err;
   assign m0.rsp_rdata = s.rsp_rdata;
   assign m1.rsp_rdata = s.rsp_rdata;
   assign s.rsp_ready  = nonempty ? ((head == ID_M1) ? m1.rsp_ready : m0.rsp_ready) : 1'b1;

   assign push     = s.cmd_valid & s.cmd_ready;
   assign pop      = s.rsp_valid & s.rsp_ready & nonempty;
   assign outs_cnt = cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         id_fifo    <= '0;
         lock       <= 1'b0;
         locked_id  <= ID_M0;
         last_grant <= ID_M1;
      end else begin
         if (push) begin
            id_fifo[wr_ptr] <= grant;
            wr_ptr          <= wr_ptr + PW'(1);
            last_grant      <= grant;
            lock            <= 1'b0;
         end else if (s.cmd_valid) begin
            lock      <= 1'b1;
            locked_id <= grant;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end
endmodule
